// File: rtl/sseg_pkg.sv
// Shared seven-segment types, the active-low hex code table and the pattern decoder.
package sseg_pkg;

  typedef logic [6:0] sseg_t;

  typedef struct packed {
    logic [3:0] nib;
    logic       blank;
    logic       err;
  } sseg_dec_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  localparam sseg_t SSEG_BLANK = 7'h7F;

  // Active-low, bit order g..a, indexed by the nibble each pattern shows.
  localparam sseg_t SSEG_CODE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic sseg_dec_t sseg_decode(sseg_t pat);
    sseg_dec_t d;
    d.nib   = 4'h0;
    d.blank = 1'b0;
    d.err   = 1'b1;
    if (pat == SSEG_BLANK) begin
      d.blank = 1'b1;
      d.err   = 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (pat == SSEG_CODE[i]) begin
          d.nib = 4'(i);
          d.err = 1'b0;
        end
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/sseg_pattern_decode.sv
// Combinational decode of one committed segment pattern into nibble/blank/error.
module sseg_pattern_decode
  import sseg_pkg::*;
(
  input  sseg_t     i_pat,
  output sseg_dec_t o_dec
);

  assign o_dec = sseg_decode(i_pat);

endmodule

// File: rtl/sseg_frame_reader.sv
// Samples a multiplexed seven-segment bus, commits stable digits and hands off
// complete frames over valid/ready.
module sseg_frame_reader
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS    = 6,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [6:0]              i_sseg,
  input  logic [NUM_DIGITS-1:0]   i_dig_sel,
  output logic [4*NUM_DIGITS-1:0] o_hex,
  output logic [NUM_DIGITS-1:0]   o_blank,
  output logic [NUM_DIGITS-1:0]   o_err,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_overrun
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]      CNT_PRE  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [NUM_DIGITS-1:0] ALL_SEEN = '1;

  sseg_t                   sseg_s1_q, sseg_s1_d, sseg_s2_q, sseg_s2_d, prev_sseg_q, prev_sseg_d;
  logic [NUM_DIGITS-1:0]   sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d, prev_sel_q, prev_sel_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic [4*NUM_DIGITS-1:0] scr_hex_q, scr_hex_d, hex_q, hex_d;
  logic [NUM_DIGITS-1:0]   scr_blank_q, scr_blank_d, blank_q, blank_d;
  logic [NUM_DIGITS-1:0]   scr_err_q, scr_err_d, err_q, err_d;
  logic                    overrun_q, overrun_d;
  out_state_e              state_q, state_d;

  logic                    sel_onehot, same_sample, commit, accept;
  logic [IDX_W-1:0]        dig_idx;
  sseg_dec_t               dec;

  assign sel_onehot  = $onehot(sel_s2_q);
  assign same_sample = (sel_s2_q == prev_sel_q) && (sseg_s2_q == prev_sseg_q);
  assign accept      = (state_q == ST_FULL) && i_ready;

  // OR-encode of the strobe; only meaningful when the strobe is one-hot.
  always_comb begin
    dig_idx = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (sel_s2_q[k]) dig_idx = dig_idx | IDX_W'(k);
    end
  end

  sseg_pattern_decode u_dec (
    .i_pat (sseg_s2_q),
    .o_dec (dec)
  );

  always_comb begin
    sseg_s1_d   = i_sseg;
    sseg_s2_d   = sseg_s1_q;
    sel_s1_d    = i_dig_sel;
    sel_s2_d    = sel_s1_q;
    prev_sseg_d = sseg_s2_q;
    prev_sel_d  = sel_s2_q;
    cnt_d       = cnt_q;
    seen_d      = seen_q;
    scr_hex_d   = scr_hex_q;
    scr_blank_d = scr_blank_q;
    scr_err_d   = scr_err_q;
    hex_d       = hex_q;
    blank_d     = blank_q;
    err_d       = err_q;
    state_d     = state_q;
    overrun_d   = 1'b0;
    commit      = 1'b0;

    // Commit fires only on the step into saturation, so long holds commit once.
    if (!sel_onehot) begin
      cnt_d = '0;
    end else if (same_sample) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
      commit = (cnt_q == CNT_PRE);
    end else begin
      cnt_d = CNT_ONE;
    end

    if (seen_q == ALL_SEEN) begin
      seen_d = '0;
      if ((state_q == ST_EMPTY) || accept) begin
        hex_d   = scr_hex_q;
        blank_d = scr_blank_q;
        err_d   = scr_err_q;
        state_d = ST_FULL;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (accept) begin
      state_d = ST_EMPTY;
    end

    // Applied after the frame clear so a commit in the completion cycle starts the next frame.
    if (commit) begin
      seen_d[dig_idx]                  = 1'b1;
      scr_hex_d[{dig_idx, 2'b00} +: 4] = dec.nib;
      scr_blank_d[dig_idx]             = dec.blank;
      scr_err_d[dig_idx]               = dec.err;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sseg_s1_q   <= SSEG_BLANK;
      sseg_s2_q   <= SSEG_BLANK;
      prev_sseg_q <= SSEG_BLANK;
      sel_s1_q    <= '0;
      sel_s2_q    <= '0;
      prev_sel_q  <= '0;
      cnt_q       <= '0;
      seen_q      <= '0;
      scr_hex_q   <= '0;
      scr_blank_q <= '0;
      scr_err_q   <= '0;
      hex_q       <= '0;
      blank_q     <= '0;
      err_q       <= '0;
      overrun_q   <= 1'b0;
      state_q     <= ST_EMPTY;
    end else begin
      sseg_s1_q   <= sseg_s1_d;
      sseg_s2_q   <= sseg_s2_d;
      prev_sseg_q <= prev_sseg_d;
      sel_s1_q    <= sel_s1_d;
      sel_s2_q    <= sel_s2_d;
      prev_sel_q  <= prev_sel_d;
      cnt_q       <= cnt_d;
      seen_q      <= seen_d;
      scr_hex_q   <= scr_hex_d;
      scr_blank_q <= scr_blank_d;
      scr_err_q   <= scr_err_d;
      hex_q       <= hex_d;
      blank_q     <= blank_d;
      err_q       <= err_d;
      overrun_q   <= overrun_d;
      state_q     <= state_d;
    end
  end

  assign o_hex     = hex_q;
  assign o_blank   = blank_q;
  assign o_err     = err_q;
  assign o_valid   = (state_q == ST_FULL);
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_sseg_frame_reader.sv
// Randomised and directed bench for sseg_frame_reader against a cycle-level behavioural model.
module tb_sseg_frame_reader;

  localparam int ND = 6;
  localparam int SC = 4;
  localparam logic [12:0] IDLE = {6'b0, 7'h7F};
  localparam logic [6:0] CODE_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic          clk = 1'b0;
  logic          rst_n;
  logic [6:0]    sseg;
  logic [ND-1:0] sel;
  logic          rdy;
  logic [4*ND-1:0] o_hex;
  logic [ND-1:0]   o_blank, o_err;
  logic            o_valid, o_overrun;

  always #5 clk = ~clk;

  sseg_frame_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_sseg    (sseg),
    .i_dig_sel (sel),
    .o_hex     (o_hex),
    .o_blank   (o_blank),
    .o_err     (o_err),
    .o_valid   (o_valid),
    .i_ready   (rdy),
    .o_overrun (o_overrun)
  );

  int n_checks = 0;
  int n_errors = 0;
  int ovr_pulses = 0;
  int vld_cycles = 0;
  int t5_hit = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural model: pin history, per-digit scratch, seen set, output holding register.
  logic [12:0]   m_p1, m_p2;
  logic [12:0]   m_hist[$];
  logic [3:0]    m_scr_nib [ND];
  logic          m_scr_blank [ND];
  logic          m_scr_err [ND];
  logic [ND-1:0] m_seen;
  logic          m_valid, m_ovr;
  logic [4*ND-1:0] m_hex;
  logic [ND-1:0]   m_blank, m_err;

  task automatic m_reset();
    m_p1 = IDLE;
    m_p2 = IDLE;
    m_hist.delete();
    for (int k = 0; k < ND; k++) begin
      m_scr_nib[k] = 4'h0;
      m_scr_blank[k] = 1'b0;
      m_scr_err[k] = 1'b0;
    end
    m_seen = '0;
    m_valid = 1'b0;
    m_ovr = 1'b0;
    m_hex = '0;
    m_blank = '0;
    m_err = '0;
  endtask

  task automatic m_edge(input logic [ND-1:0] s, input logic [6:0] p, input logic r);
    logic [12:0] cur;
    int run;
    int idx;
    logic [3:0] nib;
    logic bl, er;
    cur = m_p2;
    m_p2 = m_p1;
    m_p1 = {s, p};
    m_hist.push_back(cur);
    if (m_hist.size() > SC + 2) void'(m_hist.pop_front());
    run = 0;
    if ($countones(cur[12:7]) == 1)
      for (int j = m_hist.size() - 1; j >= 0 && m_hist[j] == cur; j--) run++;

    m_ovr = 1'b0;
    if (m_seen == '1) begin
      m_seen = '0;
      if (!m_valid || r) begin
        m_valid = 1'b1;
        for (int k = 0; k < ND; k++) begin
          m_hex[4*k +: 4] = m_scr_nib[k];
          m_blank[k] = m_scr_blank[k];
          m_err[k] = m_scr_err[k];
        end
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end

    if (run == SC) begin
      idx = 0;
      for (int k = 0; k < ND; k++) if (cur[7+k]) idx = k;
      nib = 4'h0;
      bl = (cur[6:0] == 7'h7F);
      er = !bl;
      for (int i = 0; i < 16; i++)
        if (cur[6:0] == CODE_TAB[i]) begin
          nib = 4'(i);
          er = 1'b0;
        end
      m_scr_nib[idx] = nib;
      m_scr_blank[idx] = bl;
      m_scr_err[idx] = er;
      m_seen[idx] = 1'b1;
    end
  endtask

  task automatic compare_all();
    chk_eq("valid", 32'(o_valid), 32'(m_valid));
    chk_eq("hex", 32'(o_hex), 32'(m_hex));
    chk_eq("blank", 32'(o_blank), 32'(m_blank));
    chk_eq("err", 32'(o_err), 32'(m_err));
    chk_eq("overrun", 32'(o_overrun), 32'(m_ovr));
  endtask

  task automatic cyc(input logic [ND-1:0] s, input logic [6:0] p, input logic r);
    sel = s;
    sseg = p;
    rdy = r;
    @(posedge clk);
    m_edge(s, p, r);
    @(negedge clk);
    if (o_overrun) ovr_pulses++;
    if (o_valid) vld_cycles++;
    compare_all();
  endtask

  function automatic logic [7*ND-1:0] hexpats(input logic [4*ND-1:0] h);
    logic [7*ND-1:0] r;
    for (int d = 0; d < ND; d++) r[7*d +: 7] = CODE_TAB[h[4*d +: 4]];
    return r;
  endfunction

  // mode: 0 ready low, 1 ready high, 2 random, 3 ready only in the frame-completion cycle
  task automatic scan_frame(input logic [7*ND-1:0] pats, input int hold_n, input int mode);
    logic r;
    for (int d = 0; d < ND; d++) begin
      repeat (hold_n) begin
        case (mode)
          0: r = 1'b0;
          1: r = 1'b1;
          2: r = 1'($urandom);
          default: r = (m_seen == '1);
        endcase
        cyc(ND'(1) << d, pats[7*d +: 7], r);
        if (mode == 3 && r) begin
          t5_hit++;
          chk_eq("t5_valid", 32'(o_valid), 32'd1);
          chk_eq("t5_hex", 32'(o_hex), 32'h47A5C6);
          chk_eq("t5_overrun", 32'(o_overrun), 32'd0);
        end
      end
    end
  endtask

  task automatic idle(input int n, input logic r);
    repeat (n) cyc('0, 7'h7F, r);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk_eq("rst_valid", 32'(o_valid), 32'd0);
    chk_eq("rst_hex", 32'(o_hex), 32'd0);
    chk_eq("rst_blank", 32'(o_blank), 32'd0);
    chk_eq("rst_err", 32'(o_err), 32'd0);
    chk_eq("rst_overrun", 32'(o_overrun), 32'd0);
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7*ND-1:0] pats;
    rst_n = 1'b0;
    sel = '0;
    sseg = 7'h7F;
    rdy = 1'b0;
    do_reset();

    // 1: plain scan, consumer always ready
    vld_cycles = 0;
    scan_frame(hexpats(24'h654321), 8, 1);
    idle(8, 1'b1);
    chk_eq("t1_hex", 32'(o_hex), 32'h654321);
    chk_eq("t1_blank", 32'(o_blank), 32'd0);
    chk_eq("t1_err", 32'(o_err), 32'd0);
    chk_eq("t1_vld_cycles", 32'(vld_cycles), 32'd1);

    // 2: blank and invalid patterns
    pats = hexpats(24'h000000);
    pats[7*2 +: 7] = 7'h7F;
    pats[7*4 +: 7] = 7'h55;
    scan_frame(pats, 8, 1);
    idle(8, 1'b1);
    chk_eq("t2_blank", 32'(o_blank), 32'b000100);
    chk_eq("t2_err", 32'(o_err), 32'b010000);
    chk_eq("t2_hex", 32'(o_hex), 32'd0);

    // 3: short hold and strobe glitch do not commit
    repeat (3) cyc(6'b000001, CODE_TAB[7], 1'b1);
    repeat (6) cyc(6'b000001, CODE_TAB[8], 1'b1);
    repeat (2) cyc(6'b000010, CODE_TAB[9], 1'b1);
    cyc(6'b000011, CODE_TAB[9], 1'b1);
    repeat (3) cyc(6'b000010, CODE_TAB[9], 1'b1);
    repeat (6) cyc(6'b000010, CODE_TAB[10], 1'b1);
    for (int d = 2; d < ND; d++) repeat (6) cyc(ND'(1) << d, CODE_TAB[9 + d], 1'b1);
    idle(8, 1'b1);
    chk_eq("t3_hex", 32'(o_hex), 32'hEDCBA8);

    // 4: two frames while stalled -> one overrun, first frame kept
    ovr_pulses = 0;
    scan_frame(hexpats(24'hABCDEF), 8, 0);
    scan_frame(hexpats(24'h543210), 8, 0);
    idle(8, 1'b0);
    chk_eq("t4_ovr_pulses", 32'(ovr_pulses), 32'd1);
    chk_eq("t4_hex", 32'(o_hex), 32'hABCDEF);
    chk_eq("t4_valid", 32'(o_valid), 32'd1);
    cyc('0, 7'h7F, 1'b1);
    chk_eq("t4_valid_after_accept", 32'(o_valid), 32'd0);

    // 5: completion coincides with accept
    ovr_pulses = 0;
    t5_hit = 0;
    scan_frame(hexpats(24'h102938), 8, 0);
    scan_frame(hexpats(24'h47A5C6), 8, 3);
    idle(8, 1'b0);
    chk_eq("t5_hit", 32'(t5_hit), 32'd1);
    chk_eq("t5_ovr_pulses", 32'(ovr_pulses), 32'd0);

    // 6: reset mid-scan discards held and partial frames
    pats = hexpats(24'h777777);
    for (int d = 0; d < 3; d++) repeat (8) cyc(ND'(1) << d, pats[7*d +: 7], 1'b0);
    do_reset();
    for (int d = 3; d < ND; d++) repeat (8) cyc(ND'(1) << d, pats[7*d +: 7], 1'b0);
    idle(10, 1'b0);
    chk_eq("t6_partial_valid", 32'(o_valid), 32'd0);
    scan_frame(pats, 8, 0);
    idle(4, 1'b0);
    chk_eq("t6_full_valid", 32'(o_valid), 32'd1);
    chk_eq("t6_full_hex", 32'(o_hex), 32'h777777);

    // random segments, holds, glitches and backpressure
    for (int i = 0; i < 400; i++) begin
      int d, h, kind;
      logic [6:0] p;
      logic [ND-1:0] s;
      d = int'($urandom_range(ND - 1));
      kind = int'($urandom_range(99));
      if (kind < 60) p = CODE_TAB[$urandom_range(15)];
      else if (kind < 75) p = 7'h7F;
      else p = 7'($urandom);
      s = ND'(1) << d;
      if ($urandom_range(9) == 0) s = s | (ND'(1) << ((d + 1 + int'($urandom_range(ND - 2))) % ND));
      if ($urandom_range(19) == 0) s = '0;
      h = int'($urandom_range(9, 1));
      repeat (h) cyc(s, p, 1'($urandom));
    end
    idle(10, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
